clk_gate_en_gen: RTL and testbench

- Automatic enable generator for gated register banks; it is the producer side of the EN input consumed by the clock-gated flops.
- Watches the next-state data (D_IN) against the current register contents (Q_IN) and the functional enable.
- Drops the gate enable after a programmable run of idle cycles and re-asserts it in the same cycle that new activity appears.
- Keeps a saturating count of gated cycles for power reporting.

---
 rtl/clk_gate_pkg.sv | 21 ++
 rtl/clk_gate_en_gen_if.sv | 27 ++
 rtl/sat_counter.sv | 31 +++
 rtl/clk_gate_en_gen.sv | 106 ++++++++++
 tb/tb_clk_gate_en_gen.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/clk_gate_pkg.sv
// Shared definitions for the automatic clock-gate enable generator.
//   gate_state_t        : FSM state encoding (ACTIVE, HOLD, GATED)
//   DEFAULT_IDLE_CYCLES : default run of idle cycles before gating
//   idle_cnt_width()    : width of the idle-run counter for a given IDLE_CYCLES
package clk_gate_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    HOLD   = 2'd1,
    GATED  = 2'd2
  } gate_state_t;

  localparam int unsigned DEFAULT_IDLE_CYCLES = 4;

  // The counter only ever reaches IDLE_CYCLES-1, so clog2(IDLE_CYCLES+1)
  // bits always suffice.
  function automatic int unsigned idle_cnt_width(input int unsigned idle_cycles);
    return $clog2(idle_cycles + 1);
  endfunction

endpackage

// File: rtl/clk_gate_en_gen_if.sv
// Bundle of the data/enable/statistics signals around the gate enable
// generator.
//   master : drives the monitored data and controls, observes the results
//   slave  : the enable generator itself
interface clk_gate_en_gen_if #(
  parameter int WIDTH  = 8,
  parameter int STAT_W = 16
);
  logic [WIDTH-1:0]  D_IN;       // next-state data of the gated bank
  logic [WIDTH-1:0]  Q_IN;       // current contents of the gated bank
  logic              FUNC_EN;    // functional load enable
  logic              TEST_EN;    // scan/test override, forces clock on
  logic              CLR_STAT;   // synchronous clear of GATED_CNT
  logic              GATE_EN;    // enable to the ICG cell (1 = clock runs)
  logic              IDLE;       // 1 while the FSM is in GATED
  logic [STAT_W-1:0] GATED_CNT;  // saturating count of gated cycles

  modport master (
    output D_IN, Q_IN, FUNC_EN, TEST_EN, CLR_STAT,
    input  GATE_EN, IDLE, GATED_CNT
  );

  modport slave (
    input  D_IN, Q_IN, FUNC_EN, TEST_EN, CLR_STAT,
    output GATE_EN, IDLE, GATED_CNT
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter for power statistics.
//   clk   : clock
//   rst_n : asynchronous active-low reset (count -> 0)
//   clr   : synchronous clear, has priority over inc
//   inc   : increment request; ignored once count is all-ones
//   count : current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {W{1'b1}})) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/clk_gate_en_gen.sv
// Automatic enable generator for a clock-gated register bank.
// Watches the bank's next-state data against its current contents, drops the
// gate enable after IDLE_CYCLES consecutive idle edges, and re-raises it
// combinationally as soon as a real update is pending.
//   CLK   : clock
//   RST_N : asynchronous active-low reset
//   bus   : slave side of clk_gate_en_gen_if (D_IN, Q_IN, FUNC_EN, TEST_EN,
//           CLR_STAT in; GATE_EN, IDLE, GATED_CNT out)
module clk_gate_en_gen
  import clk_gate_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES,
  parameter int STAT_W      = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  clk_gate_en_gen_if.slave     bus
);

  localparam int CNT_W = int'(idle_cnt_width(IDLE_CYCLES));
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  gate_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             idle_reg;
  logic [WIDTH-1:0] diff;
  logic             act;
  logic             gate_en;

  // A load that would not change the bank (or no load at all) is idle.
  assign diff = bus.D_IN ^ bus.Q_IN;
  assign act  = bus.FUNC_EN & (|diff);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= ACTIVE;
      cnt_reg   <= '0;
      idle_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idle_reg  <= (state_next == GATED);
    end
  end

  // Activity is checked first in every state, so an update arriving on the
  // edge that would otherwise gate keeps the bank clocked.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ACTIVE: begin
        cnt_next = '0;
        if (!act) begin
          if (IDLE_CYCLES == 1) begin
            state_next = GATED;
          end else begin
            state_next = HOLD;
            cnt_next   = CNT_ONE;
          end
        end
      end
      HOLD: begin
        if (act) begin
          state_next = ACTIVE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = GATED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      GATED: begin
        cnt_next = '0;
        if (act) begin
          state_next = ACTIVE;
        end
      end
      default: begin
        state_next = ACTIVE;
        cnt_next   = '0;
      end
    endcase
  end

  // act is ORed in combinationally so the wake costs zero cycles; the
  // downstream ICG latch filters any glitches on this path.
  assign gate_en = (state_reg != GATED) | act | bus.TEST_EN;

  assign bus.GATE_EN = gate_en;
  assign bus.IDLE    = idle_reg;

  sat_counter #(
    .W (STAT_W)
  ) u_gated_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (bus.CLR_STAT),
    .inc   (~gate_en),
    .count (bus.GATED_CNT)
  );

endmodule

// File: tb/tb_clk_gate_en_gen.sv
// Self-checking bench for clk_gate_en_gen (WIDTH=8, IDLE_CYCLES=3, STAT_W=4).
// Each table vector is applied just after a rising edge and its expected
// outputs are checked before the following edge.
module tb_clk_gate_en_gen;

  localparam int WIDTH       = 8;
  localparam int IDLE_CYCLES = 3;
  localparam int STAT_W      = 4;

  logic CLK;
  logic RST_N;

  clk_gate_en_gen_if #(.WIDTH(WIDTH), .STAT_W(STAT_W)) bus ();

  clk_gate_en_gen #(
    .WIDTH       (WIDTH),
    .IDLE_CYCLES (IDLE_CYCLES),
    .STAT_W      (STAT_W)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] d;
    logic [7:0] q;
    logic       fe;
    logic       te;
    logic       clr;
    logic       ge;
    logic       idle;
    logic [3:0] gc;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act_v, exp_v);
    end
  endtask

  task automatic check_all(input int idx, input logic ge,
                           input logic idle, input logic [3:0] gc);
    check("GATE_EN", idx, 32'(bus.GATE_EN), 32'(ge));
    check("IDLE", idx, 32'(bus.IDLE), 32'(idle));
    check("GATED_CNT", idx, 32'(bus.GATED_CNT), 32'(gc));
    $display("vec %0d: D=%h Q=%h FE=%b TE=%b CLR=%b -> GATE_EN=%b IDLE=%b CNT=%h",
             idx, bus.D_IN, bus.Q_IN, bus.FUNC_EN, bus.TEST_EN, bus.CLR_STAT,
             bus.GATE_EN, bus.IDLE, bus.GATED_CNT);
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic [7:0] q,
                              input logic fe, input logic te, input logic clr,
                              input logic ge, input logic idle, input logic [3:0] gc);
    vec_t v;
    v.d = d; v.q = q; v.fe = fe; v.te = te; v.clr = clr;
    v.ge = ge; v.idle = idle; v.gc = gc;
    return v;
  endfunction

  // Watchdog: the run is a few hundred cycles; this bound is never reached
  // by a healthy run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //                 D      Q      FE    TE    CLR   GE    IDLE  CNT
    vecs[0]  = mk(8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0); // ACTIVE
    vecs[1]  = mk(8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0); // HOLD 1
    vecs[2]  = mk(8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0); // HOLD 2
    vecs[3]  = mk(8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0); // GATED
    vecs[4]  = mk(8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1);
    vecs[5]  = mk(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h2); // wake, same cycle
    vecs[6]  = mk(8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2); // ACTIVE again
    vecs[7]  = mk(8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2); // HOLD 1
    vecs[8]  = mk(8'h00, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2); // act on boundary
    vecs[9]  = mk(8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2); // ACTIVE
    vecs[10] = mk(8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2); // FE=0 idle, HOLD 1
    vecs[11] = mk(8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h2); // HOLD 2
    vecs[12] = mk(8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2); // GATED
    vecs[13] = mk(8'h00, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3); // TEST_EN override
    vecs[14] = mk(8'h00, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3); // count frozen
    vecs[15] = mk(8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3);
    vecs[16] = mk(8'h00, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h4); // clear
    vecs[17] = mk(8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);

    // Reset held for two edges with idle inputs: nothing may gate.
    RST_N        = 1'b0;
    bus.D_IN     = 8'h00;
    bus.Q_IN     = 8'h00;
    bus.FUNC_EN  = 1'b0;
    bus.TEST_EN  = 1'b0;
    bus.CLR_STAT = 1'b0;
    #1;
    check_all(-1, 1'b1, 1'b0, 4'h0);
    for (int r = 0; r < 2; r++) begin
      @(posedge CLK);
      #1;
      check_all(-2 - r, 1'b1, 1'b0, 4'h0);
    end
    RST_N = 1'b1;

    // Table vectors: apply after the edge, check before the next one.
    for (int i = 0; i < NVEC; i++) begin
      #1;
      bus.D_IN     = vecs[i].d;
      bus.Q_IN     = vecs[i].q;
      bus.FUNC_EN  = vecs[i].fe;
      bus.TEST_EN  = vecs[i].te;
      bus.CLR_STAT = vecs[i].clr;
      #1;
      check_all(i, vecs[i].ge, vecs[i].idle, vecs[i].gc);
      @(posedge CLK);
    end

    // Long idle run: counter climbs from 1 and saturates at 4'hF.
    for (int i = 0; i < 20; i++) begin
      #2;
      check_all(100 + i, 1'b0, 1'b1, (1 + i > 15) ? 4'hF : 4'(1 + i));
      @(posedge CLK);
    end

    // One-cycle clear at saturation, then counting resumes.
    #1;
    bus.CLR_STAT = 1'b1;
    #1;
    check_all(200, 1'b0, 1'b1, 4'hF);
    @(posedge CLK);
    #1;
    bus.CLR_STAT = 1'b0;
    #1;
    check_all(201, 1'b0, 1'b1, 4'h0);
    @(posedge CLK);
    #2;
    check_all(202, 1'b0, 1'b1, 4'h1);

    // Asynchronous reset mid-cycle while gated: outputs recover without an edge.
    #1;
    RST_N = 1'b0;
    #1;
    check_all(300, 1'b1, 1'b0, 4'h0);
    @(posedge CLK);
    #1;
    check_all(301, 1'b1, 1'b0, 4'h0);
    RST_N = 1'b1;
    @(posedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
